// File: rtl/pe2_stream_if.sv
// pe2_stream_if: handshake and operand/result bundle for pe2_stream.
// With PE2_STREAM_PERF_EN defined it also carries the beat/stall counters.
`default_nettype none

interface pe2_stream_if #(
  parameter int LANES   = 2,
  parameter int COEFF_W = 12
);
  localparam int LW = LANES * COEFF_W;

  logic          in_valid_i;
  logic          in_ready_o;
  logic [2:0]    ctrl_i;
  logic [LW-1:0] a_i;
  logic [LW-1:0] b_i;
  logic [LW-1:0] w1_i;
  logic [LW-1:0] w2_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [LW-1:0] u_o;
  logic [LW-1:0] v_o;
  logic [LW-1:0] m_o;
  logic          m_valid_o;
  logic [2:0]    mode_o;
  logic          err_o;
  logic          clr_err_i;
`ifdef PE2_STREAM_PERF_EN
  logic [31:0]   beat_cnt_o;
  logic [31:0]   stall_cnt_o;
`endif

  modport slave (
`ifdef PE2_STREAM_PERF_EN
    output beat_cnt_o, stall_cnt_o,
`endif
    input  in_valid_i, ctrl_i, a_i, b_i, w1_i, w2_i, out_ready_i, clr_err_i,
    output in_ready_o, out_valid_o, u_o, v_o, m_o, m_valid_o, mode_o, err_o
  );

  modport master (
`ifdef PE2_STREAM_PERF_EN
    input  beat_cnt_o, stall_cnt_o,
`endif
    output in_valid_i, ctrl_i, a_i, b_i, w1_i, w2_i, out_ready_i, clr_err_i,
    input  in_ready_o, out_valid_o, u_o, v_o, m_o, m_valid_o, mode_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/pe2_stream.sv
// pe2_stream: LANES-wide modular butterfly stream (NTT/INTT/CWM/ADDSUB/CODECO) mod Q, valid/ready.
// Optional macro PE2_STREAM_PERF_EN adds accepted-beat and stall counters.
`default_nettype none

module pe2_stream #(
  parameter int LANES       = 2,
  parameter int COEFF_W     = 12,
  parameter int Q           = 3329,
  parameter int PIPE_STAGES = 3
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pe2_stream_if.slave bus
);
  localparam int LW   = LANES * COEFF_W;
  localparam int W2   = 2 * COEFF_W;
  localparam int NOUT = PIPE_STAGES - 2;
  localparam int OBW  = 5 + 3 * LW;

  localparam logic [COEFF_W:0] QX  = (COEFF_W + 1)'(Q);
  localparam logic [W2-1:0]    QW2 = W2'(Q);
  localparam logic [W2:0]      MU  = (W2 + 1)'((64'd1 << W2) / 64'(Q));

  localparam logic [2:0] M_NTT     = 3'd0;
  localparam logic [2:0] M_INTT    = 3'd1;
  localparam logic [2:0] M_CWM     = 3'd2;
  localparam logic [2:0] M_ADDSUB  = 3'd3;
  localparam logic [2:0] M_CODECO1 = 3'd4;
  localparam logic [2:0] M_CODECO2 = 3'd5;

  function automatic logic [COEFF_W-1:0] mod_add(input logic [COEFF_W-1:0] x, input logic [COEFF_W-1:0] y);
    logic [COEFF_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QX) s = s - QX;
    return COEFF_W'(s);
  endfunction

  function automatic logic [COEFF_W-1:0] mod_sub(input logic [COEFF_W-1:0] x, input logic [COEFF_W-1:0] y);
    logic [COEFF_W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + QX;
    return COEFF_W'(d);
  endfunction

  // Quotient estimate is at most one low since x < 2^W2, so one subtract suffices.
  function automatic logic [COEFF_W-1:0] barrett(input logic [W2-1:0] x);
    logic [2*W2:0] prod;
    logic [W2-1:0] qe;
    logic [W2-1:0] r;
    prod = {{(W2 + 1){1'b0}}, x} * {{W2{1'b0}}, MU};
    qe   = W2'(prod >> W2);
    r    = x - qe * QW2;
    if (r >= QW2) r = r - QW2;
    return COEFF_W'(r);
  endfunction

  logic             adv;
  logic             accept;
  logic             bad_in;
  logic [LANES-1:0] lane_bad;
  logic             err;

  logic             v1, v2;
  logic [2:0]       mode1, mode2;
  logic [LW-1:0]    x1, x2, wa, wb, t1, t2;
  wire  [LW-1:0]    x1_n, x2_n, t1_n, t2_n, u_n, v_n, m_n;
  logic [OBW-1:0]   ob [NOUT];

  assign adv            = bus.out_ready_i || !bus.out_valid_o;
  assign bus.in_ready_o = adv;
  assign accept         = bus.in_valid_i && adv;
  assign bad_in         = (|lane_bad) || (bus.ctrl_i[2:1] == 2'b11);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [COEFF_W-1:0] a, b, s, d, t1s, t2s, u, v, m;
    logic [W2-1:0]      p1, p2;

    assign a = bus.a_i[k*COEFF_W +: COEFF_W];
    assign b = bus.b_i[k*COEFF_W +: COEFF_W];
    assign s = mod_add(a, b);
    assign d = mod_sub(a, b);
    assign lane_bad[k] = ({1'b0, a} >= QX) || ({1'b0, b} >= QX) ||
                         ({1'b0, bus.w1_i[k*COEFF_W +: COEFF_W]} >= QX) ||
                         ({1'b0, bus.w2_i[k*COEFF_W +: COEFF_W]} >= QX);

    // INTT multiplies the pre-add results; ADDSUB carries them straight through.
    assign x1_n[k*COEFF_W +: COEFF_W] = (bus.ctrl_i == M_INTT || bus.ctrl_i == M_ADDSUB) ? s : a;
    assign x2_n[k*COEFF_W +: COEFF_W] = (bus.ctrl_i == M_INTT || bus.ctrl_i == M_ADDSUB) ? d : b;

    assign p1 = {{COEFF_W{1'b0}}, x1[k*COEFF_W +: COEFF_W]} * {{COEFF_W{1'b0}}, wa[k*COEFF_W +: COEFF_W]};
    assign p2 = {{COEFF_W{1'b0}}, x2[k*COEFF_W +: COEFF_W]} * {{COEFF_W{1'b0}}, wb[k*COEFF_W +: COEFF_W]};
    assign t1_n[k*COEFF_W +: COEFF_W] = (mode1 == M_ADDSUB) ? x1[k*COEFF_W +: COEFF_W] : barrett(p1);
    assign t2_n[k*COEFF_W +: COEFF_W] = (mode1 == M_ADDSUB) ? x2[k*COEFF_W +: COEFF_W] : barrett(p2);

    assign t1s = t1[k*COEFF_W +: COEFF_W];
    assign t2s = t2[k*COEFF_W +: COEFF_W];

    always_comb begin
      u = '0;
      v = '0;
      m = '0;
      case (mode2)
        M_NTT: begin
          u = mod_add(t1s, t2s);
          v = mod_sub(t1s, t2s);
        end
        M_CWM: begin
          u = t1s;
          v = t2s;
          m = mod_add(t1s, t2s);
        end
        M_INTT, M_ADDSUB, M_CODECO1, M_CODECO2: begin
          u = t1s;
          v = t2s;
        end
        default: ;
      endcase
    end

    assign u_n[k*COEFF_W +: COEFF_W] = u;
    assign v_n[k*COEFF_W +: COEFF_W] = v;
    assign m_n[k*COEFF_W +: COEFF_W] = m;
  end

  // ob[0] is the post-add register; ob[1..] are latency-balancing copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      mode1 <= '0;
      mode2 <= '0;
      x1    <= '0;
      x2    <= '0;
      wa    <= '0;
      wb    <= '0;
      t1    <= '0;
      t2    <= '0;
      for (int i = 0; i < NOUT; i++) ob[i] <= '0;
    end else if (adv) begin
      v1    <= bus.in_valid_i;
      mode1 <= bus.ctrl_i;
      x1    <= x1_n;
      x2    <= x2_n;
      wa    <= bus.w1_i;
      wb    <= bus.w2_i;
      v2    <= v1;
      mode2 <= mode1;
      t1    <= t1_n;
      t2    <= t2_n;
      ob[0] <= {v2, v2 && (mode2 == M_CWM), mode2, u_n, v_n, m_n};
      for (int i = 1; i < NOUT; i++) ob[i] <= ob[i-1];
    end
  end

  assign bus.out_valid_o = ob[NOUT-1][OBW-1];
  assign bus.m_valid_o   = ob[NOUT-1][OBW-2];
  assign bus.mode_o      = ob[NOUT-1][OBW-3 -: 3];
  assign bus.u_o         = ob[NOUT-1][3*LW-1 -: LW];
  assign bus.v_o         = ob[NOUT-1][2*LW-1 -: LW];
  assign bus.m_o         = ob[NOUT-1][LW-1:0];

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 err <= 1'b0;
    else if (accept && bad_in) err <= 1'b1;
    else if (bus.clr_err_i)   err <= 1'b0;
  end

  assign bus.err_o = err;

`ifdef PE2_STREAM_PERF_EN
  logic [31:0] beat_cnt, stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else if (bus.clr_err_i) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) beat_cnt <= beat_cnt + 32'd1;
      if (bus.out_valid_o && !bus.out_ready_i) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.beat_cnt_o  = beat_cnt;
  assign bus.stall_cnt_o = stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe2_stream.sv
// tb_pe2_stream: directed + random stimulus with a scoreboard of expected output beats.
`default_nettype none

module tb_pe2_stream;
  localparam int LANES       = 2;
  localparam int COEFF_W     = 12;
  localparam int Q           = 3329;
  localparam int PIPE_STAGES = 3;
  localparam int LW          = LANES * COEFF_W;

  typedef struct packed {
    logic [LW-1:0] u;
    logic [LW-1:0] v;
    logic [LW-1:0] m;
    logic          mv;
    logic [2:0]    mode;
  } beat_t;

  typedef struct packed {
    logic  care;
    beat_t b;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    stall_seen = 0;
  bit    rand_ready = 1'b0;
  exp_t  sb[$];
  beat_t obs;

  pe2_stream_if #(.LANES(LANES), .COEFF_W(COEFF_W)) bus ();

  pe2_stream #(
    .LANES(LANES), .COEFF_W(COEFF_W), .Q(Q), .PIPE_STAGES(PIPE_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.u_o, bus.v_o, bus.m_o, bus.m_valid_o, bus.mode_o};

  function automatic exp_t model(input logic [2:0] c, input logic [LW-1:0] a, input logic [LW-1:0] b,
                                 input logic [LW-1:0] w1, input logic [LW-1:0] w2);
    exp_t   e;
    longint ak, bk, xk, yk, s, d, p1, p2, u, v, m;
    e        = '0;
    e.care   = 1'b1;
    e.b.mode = c;
    e.b.mv   = (c == 3'd2);
    for (int k = 0; k < LANES; k++) begin
      ak = longint'(a[k*COEFF_W +: COEFF_W]);
      bk = longint'(b[k*COEFF_W +: COEFF_W]);
      xk = longint'(w1[k*COEFF_W +: COEFF_W]);
      yk = longint'(w2[k*COEFF_W +: COEFF_W]);
      if (ak >= Q || bk >= Q || xk >= Q || yk >= Q) e.care = 1'b0;
      s  = (ak + bk) % Q;
      d  = (ak - bk + Q) % Q;
      p1 = (ak * xk) % Q;
      p2 = (bk * yk) % Q;
      u = 0; v = 0; m = 0;
      case (c)
        3'd0: begin u = (p1 + p2) % Q; v = (p1 - p2 + Q) % Q; end
        3'd1: begin u = (s * xk) % Q;  v = (d * yk) % Q; end
        3'd2: begin u = p1; v = p2; m = (p1 + p2) % Q; end
        3'd3: begin u = s;  v = d; end
        3'd4, 3'd5: begin u = p1; v = p2; end
        default: ;
      endcase
      e.b.u[k*COEFF_W +: COEFF_W] = COEFF_W'(u);
      e.b.v[k*COEFF_W +: COEFF_W] = COEFF_W'(v);
      e.b.m[k*COEFF_W +: COEFF_W] = COEFF_W'(m);
    end
    return e;
  endfunction

  // Output side: compare every valid output cycle (held or taken) with the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b0) stall_seen++;
      if (bus.out_valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_beat: observed out_valid=1 mode=%0d, required no beat outstanding", bus.mode_o);
        end else begin
          if (sb[0].care) begin
            checks++;
            assert (obs === sb[0].b) else begin
              errors++;
              $error("FAIL %s: observed=%h required=%h", bus.out_ready_i ? "beat" : "held_beat", obs, sb[0].b);
            end
          end
          if (bus.out_ready_i === 1'b1) void'(sb.pop_front());
        end
      end
      if (bus.in_valid_i === 1'b1 && bus.in_ready_o === 1'b1)
        sb.push_back(model(bus.ctrl_i, bus.a_i, bus.b_i, bus.w1_i, bus.w2_i));
    end
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d required=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [2:0] c, input logic [LW-1:0] a, input logic [LW-1:0] b,
                      input logic [LW-1:0] w1, input logic [LW-1:0] w2);
    bit ok;
    int n;
    bus.ctrl_i = c; bus.a_i = a; bus.b_i = b; bus.w1_i = w1; bus.w2_i = w2;
    bus.in_valid_i = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (bus.in_ready_o === 1'b1);
      tick();
      n++;
    end
    bus.in_valid_i = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed in_ready=0 for %0d cycles, required acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed %0d beats outstanding, required 0", sb.size());
    end
  endtask

  function automatic logic [LW-1:0] rvec();
    logic [LW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*COEFF_W +: COEFF_W] = COEFF_W'($urandom_range(0, Q - 1));
    return r;
  endfunction

  function automatic logic [LW-1:0] lane0(input int x);
    logic [LW-1:0] r;
    r = '0;
    r[COEFF_W-1:0] = COEFF_W'(x);
    return r;
  endfunction

  initial begin
    logic [2:0]    c5;
    logic [LW-1:0] a5, b5, x5, y5;

    bus.in_valid_i = 1'b0; bus.ctrl_i = '0;
    bus.a_i = '0; bus.b_i = '0; bus.w1_i = '0; bus.w2_i = '0;
    bus.out_ready_i = 1'b1; bus.clr_err_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_m_valid",   bus.m_valid_o, 0);
    chk("rst_err",       bus.err_o, 0);
    chk("rst_u",         bus.u_o, 0);
    chk("rst_v",         bus.v_o, 0);
    chk("rst_m",         bus.m_o, 0);
    chk("rst_mode",      bus.mode_o, 0);
    chk("rst_in_ready",  bus.in_ready_o, 1);
    tick();

    // NTT single beat: latency and lane0/lane1 values
    send(3'd0, lane0(10), lane0(2), lane0(999), lane0(5));
    chk("ntt_lat1", bus.out_valid_o, 0);
    tick();
    chk("ntt_lat2", bus.out_valid_o, 0);
    tick();
    chk("ntt_lat3", bus.out_valid_o, 1);
    chk("ntt_u", bus.u_o, 13);
    chk("ntt_v", bus.v_o, 3322);
    chk("ntt_m_valid", bus.m_valid_o, 0);
    drain();

    // Back-to-back mixed modes
    send(3'd2, lane0(100), lane0(50), lane0(4), lane0(2));
    send(3'd3, lane0(1000), lane0(2500), lane0(0), lane0(0));
    send(3'd1, lane0(20), lane0(10), lane0(999), lane0(2));
    chk("cwm_u", bus.u_o, 400);
    chk("cwm_v", bus.v_o, 100);
    chk("cwm_m", bus.m_o, 500);
    chk("cwm_m_valid", bus.m_valid_o, 1);
    tick();
    chk("addsub_u", bus.u_o, 171);
    chk("addsub_v", bus.v_o, 1829);
    chk("addsub_m_valid", bus.m_valid_o, 0);
    tick();
    chk("intt_u", bus.u_o, 9);
    chk("intt_v", bus.v_o, 20);
    chk("intt_mode", bus.mode_o, 1);
    drain();

    // Backpressure: 10 beats, downstream blocked for 5 cycles mid-stream
    for (int i = 0; i < 4; i++) send(3'($urandom_range(0, 5)), rvec(), rvec(), rvec(), rvec());
    c5 = 3'($urandom_range(0, 5)); a5 = rvec(); b5 = rvec(); x5 = rvec(); y5 = rvec();
    bus.out_ready_i = 1'b0;
    bus.ctrl_i = c5; bus.a_i = a5; bus.b_i = b5; bus.w1_i = x5; bus.w2_i = y5;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", bus.in_ready_o, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready_i = 1'b1;
    send(c5, a5, b5, x5, y5);
    for (int i = 0; i < 5; i++) send(3'($urandom_range(0, 5)), rvec(), rvec(), rvec(), rvec());
    drain();

    // Asynchronous reset with beats in flight
    for (int i = 0; i < 3; i++) send(3'd0, rvec(), rvec(), rvec(), rvec());
    chk("prerst_valid", bus.out_valid_o, 1);
    #3 rst = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", bus.out_valid_o, 0);
    chk("midrst_u", bus.u_o, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (4) tick();
    chk("postrst_no_stale", bus.out_valid_o, 0);
    send(3'd0, lane0(10), lane0(2), lane0(999), lane0(5));
    drain();

    // Error flag: reserved ctrl, clear, out-of-range operand, set-over-clear
    send(3'd7, lane0(5), lane0(6), lane0(7), lane0(8));
    chk("err_reserved", bus.err_o, 1);
    drain();
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    chk("err_cleared", bus.err_o, 0);
    send(3'd0, lane0(3329), lane0(1), lane0(1), lane0(1));
    chk("err_operand_a", bus.err_o, 1);
    drain();
    bus.clr_err_i = 1'b1;
    tick();
    chk("err_cleared2", bus.err_o, 0);
    send(3'd3, lane0(1), lane0(1), lane0(1), {12'd4000, 12'd1});
    bus.clr_err_i = 1'b0;
    chk("err_set_wins", bus.err_o, 1);
    drain();
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    chk("err_cleared3", bus.err_o, 0);

    // 200 random beats, random downstream readiness
    stall_seen = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) send(3'($urandom_range(0, 5)), rvec(), rvec(), rvec(), rvec());
    drain();
    rand_ready = 1'b0;
    bus.out_ready_i = 1'b1;
    tick();
    chk("rand_err_clean", bus.err_o, 0);
`ifdef PE2_STREAM_PERF_EN
    chk("beat_cnt", bus.beat_cnt_o, 200);
    chk("stall_cnt", bus.stall_cnt_o, stall_seen);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
